// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan display.
package seg_pkg;

    localparam int unsigned SCAN_DIV_DEFAULT = 100000;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high; dp never lit.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_R     = 8'h50;
    localparam logic [7:0] SEG_Y     = 8'h6E;
    localparam logic [7:0] SEG_G     = 8'h3D;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        KIND_DIGIT  = 2'd0,
        KIND_LETTER = 2'd1,
        KIND_BLANK  = 2'd2
    } kind_e;

    typedef struct packed {
        logic [4:0] count;
        logic [2:0] fl;
        logic [2:0] hl;
    } snap_t;

    function automatic logic [1:0] tens_of(input logic [4:0] c);
        if (c >= 5'd30)      return 2'd3;
        else if (c >= 5'd20) return 2'd2;
        else if (c >= 5'd10) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [4:0] c);
        logic [4:0] u;
        case (tens_of(c))
            2'd3:    u = c - 5'd30;
            2'd2:    u = c - 5'd20;
            2'd1:    u = c - 5'd10;
            default: u = c;
        endcase
        return u[3:0];
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Light-state/countdown inputs and scanned segment outputs of the display.
interface seg_scan_display_if;
    logic [4:0] count;
    logic [2:0] fl;
    logic [2:0] hl;
    logic [7:0] LED_l;
    logic [7:0] LED_h;
    logic [7:0] sel;

    modport master (output count, output fl, output hl,
                    input LED_l, input LED_h, input sel);
    modport slave  (input count, input fl, input hl,
                    output LED_l, output LED_h, output sel);
endinterface

// File: rtl/seg7_encode.sv
// Combinational seven-segment encoder for digits, light letters and blanks.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  kind_e      kind,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (kind)
            KIND_DIGIT: begin
                case (value)
                    4'd0:    seg = SEG_0;
                    4'd1:    seg = SEG_1;
                    4'd2:    seg = SEG_2;
                    4'd3:    seg = SEG_3;
                    4'd4:    seg = SEG_4;
                    4'd5:    seg = SEG_5;
                    4'd6:    seg = SEG_6;
                    4'd7:    seg = SEG_7;
                    4'd8:    seg = SEG_8;
                    4'd9:    seg = SEG_9;
                    default: seg = SEG_BLANK;
                endcase
            end
            // Letter value carries a light code; anything not one-hot shows E.
            KIND_LETTER: begin
                case (value)
                    {1'b0, RED}: seg = SEG_R;
                    {1'b0, YEL}: seg = SEG_Y;
                    {1'b0, GRN}: seg = SEG_G;
                    default:     seg = SEG_E;
                endcase
            end
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// 8-digit multiplexed seven-segment driver for the traffic controller countdown and lights.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic                clk100M,
    input  logic                rst,
    seg_scan_display_if.slave   bus
);

    localparam int unsigned     PRE_W   = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic             started_q, started_d;
    snap_t            snap_q, snap_d;
    logic [7:0]       sel_q, sel_d;
    logic [7:0]       led_l_q, led_l_d;
    logic [7:0]       led_h_q, led_h_d;

    logic             tick;
    logic [3:0]       dig_value;
    kind_e            dig_kind;
    logic [7:0]       dig_seg;
    logic [1:0]       tens;

    seg7_encode u_enc (
        .value (dig_value),
        .kind  (dig_kind),
        .seg   (dig_seg)
    );

    always_comb begin
        // Prescaler waits for the start-up edge so digit 0 is held a full SCAN_DIV.
        tick      = started_q && (pre_q == PRE_MAX);
        pre_d     = pre_q;
        idx_d     = idx_q;
        started_d = 1'b1;
        snap_d    = snap_q;
        if (started_q) pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) idx_d = idx_q + 3'd1;
        if (!started_q || (tick && idx_q == 3'd7)) snap_d = {bus.count, bus.fl, bus.hl};

        tens      = tens_of(snap_q.count);
        dig_value = '0;
        dig_kind  = KIND_BLANK;
        case (idx_q)
            3'd0: begin
                dig_value = units_of(snap_q.count);
                dig_kind  = KIND_DIGIT;
            end
            3'd1: begin
                dig_value = {2'b00, tens};
                dig_kind  = (tens != 2'd0) ? KIND_DIGIT : KIND_BLANK;
            end
            3'd3: begin
                dig_value = {1'b0, snap_q.hl};
                dig_kind  = KIND_LETTER;
            end
            3'd4: begin
                dig_value = {1'b0, snap_q.fl};
                dig_kind  = KIND_LETTER;
            end
            default: begin
                dig_value = '0;
                dig_kind  = KIND_BLANK;
            end
        endcase

        // Outputs stay dark until the first snapshot has been captured.
        sel_d   = started_q ? (8'b1 << idx_q) : '0;
        led_l_d = (started_q && !idx_q[2]) ? dig_seg : '0;
        led_h_d = (started_q &&  idx_q[2]) ? dig_seg : '0;
    end

    always_ff @(posedge clk100M) begin
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
            snap_q    <= '0;
            sel_q     <= '0;
            led_l_q   <= '0;
            led_h_q   <= '0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            snap_q    <= snap_d;
            sel_q     <= sel_d;
            led_l_q   <= led_l_d;
            led_h_q   <= led_h_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.LED_l = led_l_q;
    assign bus.LED_h = led_h_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with SCAN_DIV = 4 and directed frames.
module tb_seg_scan_display;

    logic clk100M = 1'b0;
    logic rst     = 1'b1;

    seg_scan_display_if bus ();

    seg_scan_display #(.SCAN_DIV(4)) dut (
        .clk100M (clk100M),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk100M = ~clk100M;

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  l;
        logic [7:0]  h;
        int unsigned hold;   // samples this value must persist; 0 = unchecked
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_on = 1'b0;

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk100M);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] l, input logic [7:0] h,
                        input int unsigned hold);
        exp_t e;
        e.sel  = s;
        e.l    = l;
        e.h    = h;
        e.hold = hold;
        exp_q.push_back(e);
    endtask

    // Pushes the first ndig digits of a frame showing d0,d1,d3,d4 (other digits blank).
    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d3, input logic [7:0] d4,
                              input int unsigned ndig, input int unsigned last_hold);
        logic [7:0] segs [8];
        segs[0] = d0;  segs[1] = d1;  segs[2] = 8'h00; segs[3] = d3;
        segs[4] = d4;  segs[5] = 8'h00; segs[6] = 8'h00; segs[7] = 8'h00;
        for (int unsigned i = 0; i < ndig; i++)
            push(8'(1 << i), (i < 4) ? segs[i] : 8'h00, (i >= 4) ? segs[i] : 8'h00,
                 (i == ndig - 1) ? last_hold : 4);
    endtask

    // Monitor: every change of the output triple presents one scoreboard entry.
    initial begin
        logic [23:0] last;
        logic [23:0] now;
        exp_t        cur;
        int unsigned run;
        bit          have;
        last = '1;
        run  = 0;
        have = 1'b0;
        cur  = '{sel: 8'h00, l: 8'h00, h: 8'h00, hold: 0};
        forever begin
            @(negedge clk100M);
            if (mon_on) begin
                now = {bus.sel, bus.LED_l, bus.LED_h};
                if (now == last) begin
                    run++;
                end else begin
                    if (have && cur.hold != 0) begin
                        checks++;
                        if (run != cur.hold) begin
                            errors++;
                            $display("FAIL hold sel=%02h: held %0d cycles, required %0d",
                                     cur.sel, run, cur.hold);
                        end
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        have = 1'b0;
                        $display("FAIL underflow: got sel=%02h l=%02h h=%02h, nothing expected",
                                 bus.sel, bus.LED_l, bus.LED_h);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                        checks++;
                        if (bus.sel !== cur.sel || bus.LED_l !== cur.l || bus.LED_h !== cur.h) begin
                            errors++;
                            $display("FAIL output: got sel=%02h l=%02h h=%02h, required sel=%02h l=%02h h=%02h",
                                     bus.sel, bus.LED_l, bus.LED_h, cur.sel, cur.l, cur.h);
                        end
                        if (bus.sel != 8'h00) begin
                            checks++;
                            if (!$onehot(bus.sel)) begin
                                errors++;
                                $display("FAIL onehot: got sel=%02h, required one bit set", bus.sel);
                            end
                        end
                    end
                    last = now;
                    run  = 1;
                end
            end
        end
    end

    initial begin
        bus.count = 5'd27;
        bus.hl    = 3'b100;
        bus.fl    = 3'b001;
        rst       = 1'b1;
        push(8'h00, 8'h00, 8'h00, 0);
        cyc(1);
        mon_on = 1'b1;
        cyc(2);
        rst = 1'b0;

        // Frame 0: 27, r, G.  count changes during idx 0 but must wait a frame.
        push_frame(8'h07, 8'h5B, 8'h50, 8'h3D, 8, 4);
        cyc(2);
        bus.count = 5'd14;
        push_frame(8'h66, 8'h06, 8'h50, 8'h3D, 8, 4);

        cyc(32);
        bus.count = 5'd5;
        push_frame(8'h6D, 8'h00, 8'h50, 8'h3D, 8, 4);

        cyc(32);
        bus.count = 5'd0;
        push_frame(8'h3F, 8'h00, 8'h50, 8'h3D, 8, 4);

        cyc(32);
        bus.count = 5'd31;
        bus.hl    = 3'b110;
        bus.fl    = 3'b000;
        // Reset lands while digit 5 is showing: it is cut to one cycle, then dark.
        push_frame(8'h06, 8'h4F, 8'h79, 8'h79, 6, 1);
        push(8'h00, 8'h00, 8'h00, 3);

        cyc(52);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        push_frame(8'h06, 8'h4F, 8'h79, 8'h79, 8, 4);
        push_frame(8'h06, 8'h4F, 8'h79, 8'h79, 8, 4);
        push_frame(8'h06, 8'h4F, 8'h79, 8'h79, 1, 0);

        cyc(67);
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
